// File: rtl/seg_pkg.sv
// Shared constants for the scrolling 7-segment driver: mode encodings, scroll direction,
// segment patterns {a,b,c,d,e,f,g} with a as MSB, and a counter-width helper.
package seg_pkg;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_WRAP_L = 2'b01;
    localparam logic [1:0] MODE_WRAP_R = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1111110, // 0
        7'b0110000, // 1
        7'b1101101, // 2
        7'b1111001, // 3
        7'b0110011, // 4
        7'b1011011, // 5
        7'b1011111, // 6
        7'b1110000, // 7
        7'b1111111, // 8
        7'b1111011, // 9
        7'b1110111, // A
        7'b0011111, // b
        7'b1001110, // C
        7'b0111101, // d
        7'b1001111, // E
        7'b1000111  // F
    };

    // Width of a counter running 0..div-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to 7-segment pattern, segments {a,b,c,d,e,f,g}, active-high.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_HEX[nibble];
    end

endmodule

// File: rtl/seg_scroll_ctrl.sv
// Scrolling hex message driver for a multiplexed common-ground 7-segment display.
// Optional blanking blink is built only when SEG_BLINK_EN is defined.
module seg_scroll_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned N_DIGITS  = 4,
    parameter int unsigned MSG_LEN   = 18,
    parameter int unsigned SCAN_DIV  = 32768,
    parameter int unsigned STEP_DIV  = 2 ** 25,
    parameter int unsigned BLINK_DIV = 2 ** 22
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [3:0]                 wr_data,
    input  logic [1:0]                 mode,
    input  logic                       fast,
    input  logic                       blink_en,
    output logic [$clog2(MSG_LEN)-1:0] pos,
    output logic [N_DIGITS-1:0]        digit_sel,
    output logic [6:0]                 seg
);

    localparam int unsigned PW  = $clog2(MSG_LEN);
    localparam int unsigned IW  = PW + 1;
    localparam int unsigned KW  = cnt_width(N_DIGITS);
    localparam int unsigned SCW = cnt_width(SCAN_DIV);
    localparam int unsigned STW = cnt_width(STEP_DIV);

    localparam logic [SCW-1:0] SCAN_TERM      = SCW'(SCAN_DIV - 1);
    localparam logic [STW-1:0] STEP_TERM_SLOW = STW'(STEP_DIV - 1);
    localparam logic [STW-1:0] STEP_TERM_FAST = STW'(STEP_DIV / 2 - 1);
    localparam logic [KW-1:0]  K_LAST         = KW'(N_DIGITS - 1);
    localparam logic [PW-1:0]  POS_MAX        = PW'(MSG_LEN - 1);
    localparam logic [PW-1:0]  POS_TOP        = PW'(MSG_LEN - N_DIGITS);
    localparam logic [IW-1:0]  MSG_LEN_W      = IW'(MSG_LEN);

    logic [3:0]          msg_q [MSG_LEN];
    logic [3:0]          msg_d [MSG_LEN];
    logic [SCW-1:0]      scan_cnt_q, scan_cnt_d;
    logic [KW-1:0]       scan_idx_q, scan_idx_d;
    logic [STW-1:0]      step_cnt_q, step_cnt_d;
    logic [PW-1:0]       pos_q, pos_d;
    logic                dir_q, dir_d;
    logic [N_DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic [6:0]          seg_q, seg_d;

    logic                scan_tick;
    logic                step_tick;
    logic [STW-1:0]      step_term;
    logic [IW-1:0]       idx_sum;
    logic [PW-1:0]       rd_idx;
    logic [6:0]          dec_seg;

    // pos + k stays below 2*MSG_LEN, so one conditional subtract is a full modulo.
    always_comb begin
        idx_sum = IW'(pos_q) + IW'(scan_idx_q);
        rd_idx  = (idx_sum >= MSG_LEN_W) ? PW'(idx_sum - MSG_LEN_W) : PW'(idx_sum);
    end

    seg_hex_decode u_dec (
        .nibble (msg_q[rd_idx]),
        .seg    (dec_seg)
    );

    always_comb begin
        msg_d = msg_q;
        if (wr_en && (32'(wr_addr) < MSG_LEN)) begin
            msg_d[wr_addr] = wr_data;
        end
    end

    // The slot lit on a tick is the current index; the index then moves on.
    always_comb begin
        scan_tick   = (scan_cnt_q == SCAN_TERM);
        scan_cnt_d  = scan_tick ? '0 : scan_cnt_q + SCW'(1);
        scan_idx_d  = scan_idx_q;
        digit_sel_d = digit_sel_q;
        seg_d       = seg_q;
        if (scan_tick) begin
            scan_idx_d  = (scan_idx_q == K_LAST) ? '0 : scan_idx_q + KW'(1);
            digit_sel_d = ~(N_DIGITS'(1) << scan_idx_q);
            seg_d       = dec_seg;
        end
    end

    // Compare with >= so lowering the terminal via fast steps at once if already past it.
    always_comb begin
        step_term  = fast ? STEP_TERM_FAST : STEP_TERM_SLOW;
        step_tick  = (step_cnt_q >= step_term);
        step_cnt_d = step_tick ? '0 : step_cnt_q + STW'(1);
    end

    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (step_tick) begin
            case (mode)
                MODE_WRAP_L: pos_d = (pos_q == POS_MAX) ? '0 : pos_q + PW'(1);
                MODE_WRAP_R: pos_d = (pos_q == '0) ? POS_MAX : pos_q - PW'(1);
                MODE_BOUNCE: begin
                    if (pos_q > POS_TOP) begin
                        pos_d = POS_TOP;
                        dir_d = DIR_DOWN;
                    end else if (((dir_q == DIR_UP) && (pos_q != POS_TOP)) || (pos_q == '0)) begin
                        pos_d = pos_q + PW'(1);
                        dir_d = (pos_q + PW'(1) == POS_TOP) ? DIR_DOWN : DIR_UP;
                    end else begin
                        pos_d = pos_q - PW'(1);
                        dir_d = (pos_q == PW'(1)) ? DIR_UP : DIR_DOWN;
                    end
                end
                default: pos_d = pos_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            scan_idx_q  <= '0;
            step_cnt_q  <= '0;
            pos_q       <= '0;
            dir_q       <= DIR_UP;
            digit_sel_q <= '1;
            seg_q       <= SEG_BLANK;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            scan_idx_q  <= scan_idx_d;
            step_cnt_q  <= step_cnt_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            digit_sel_q <= digit_sel_d;
            seg_q       <= seg_d;
        end
    end

    // Message contents survive reset.
    always_ff @(posedge clk) begin
        msg_q <= msg_d;
    end

    assign pos       = pos_q;
    assign digit_sel = digit_sel_q;

`ifdef SEG_BLINK_EN
    localparam int unsigned BLW = cnt_width(BLINK_DIV);
    localparam logic [BLW-1:0] BLINK_TERM = BLW'(BLINK_DIV - 1);

    logic [BLW-1:0] blink_cnt_q, blink_cnt_d;
    logic           blink_on_q, blink_on_d;

    always_comb begin
        blink_cnt_d = (blink_cnt_q == BLINK_TERM) ? '0 : blink_cnt_q + BLW'(1);
        blink_on_d  = (blink_cnt_q == BLINK_TERM) ? ~blink_on_q : blink_on_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign seg = (blink_en && blink_on_q) ? SEG_BLANK : seg_q;
`else
    logic unused_blink;
    assign unused_blink = blink_en ^ (BLINK_DIV == 0);
    assign seg          = seg_q;
`endif

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Scoreboard bench for seg_scroll_ctrl: expected scan slots are queued per phase and
// popped whenever the DUT lights a new digit; timing-specific items are checked directly.
module tb_seg_scroll_ctrl;

    localparam int N_DIG = 4;
    localparam int M_LEN = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic [1:0] mode = 2'b00;
    logic       fast = 1'b0;
    logic       blink_en = 1'b0;
    logic [2:0] pos;
    logic [3:0] digit_sel;
    logic [6:0] seg;

    seg_scroll_ctrl #(
        .N_DIGITS  (N_DIG),
        .MSG_LEN   (M_LEN),
        .SCAN_DIV  (4),
        .STEP_DIV  (16),
        .BLINK_DIV (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .mode      (mode),
        .fast      (fast),
        .blink_en  (blink_en),
        .pos       (pos),
        .digit_sel (digit_sel),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] dsel;
        logic [6:0] seg;
        logic [2:0] pos;
    } exp_t;

    exp_t       exp_q [$];
    logic [3:0] msg_m [M_LEN];
    logic [3:0] mon_prev = 4'hF;
    bit         mon_on = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] hex_ref(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    function automatic logic [3:0] dsel_ref(input int k);
        logic [3:0] one;
        one = 4'b0001 << k;
        return ~one;
    endfunction

    // Window start after n steps from reset (pos 0, direction up).
    function automatic int pos_model(input logic [1:0] m, input int n);
        int seq [4];
        seq = '{0, 1, 2, 1};
        case (m)
            2'b01:   return n % M_LEN;
            2'b10:   return (M_LEN - (n % M_LEN)) % M_LEN;
            2'b11:   return seq[n % 4];
            default: return 0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!mon_on) begin
            mon_prev = 4'hF;
        end else begin
            if (digit_sel !== mon_prev && digit_sel !== 4'hF) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_slot", {28'd0, digit_sel}, 32'hF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("slot_dsel", {28'd0, digit_sel}, {28'd0, e.dsel});
                    check("slot_seg", {25'd0, seg}, {25'd0, e.seg});
                    check("slot_pos", {29'd0, pos}, {29'd0, e.pos});
                end
            end
            mon_prev = digit_sel;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // After return, the next rising edge is edge 1 of a fresh run.
    task automatic do_reset();
        mon_on = 1'b0;
        wr_en  = 1'b0;
        rst    = 1'b1;
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic run_phase(input logic [1:0] m, input logic f, input int nslots,
                             input int wcyc, input logic [2:0] waddr, input logic [3:0] wdata);
        int per;
        mode     = m;
        fast     = f;
        blink_en = 1'b0;
        do_reset();
        per = f ? 8 : 16;
        for (int s = 1; s <= nslots; s++) begin
            int   e;
            int   k;
            int   idx;
            logic [3:0] v;
            exp_t x;
            e   = 4 * s;
            k   = (s - 1) % N_DIG;
            idx = (pos_model(m, (e - 1) / per) + k) % M_LEN;
            v   = msg_m[idx];
            if (wcyc != 0 && wcyc < e && int'(waddr) == idx) v = wdata;
            x.dsel = dsel_ref(k);
            x.seg  = hex_ref(v);
            x.pos  = 3'(pos_model(m, e / per));
            exp_q.push_back(x);
        end
        mon_on = 1'b1;
        for (int c = 1; c <= nslots * 4 + 8; c++) begin
            wr_en   = (c == wcyc);
            wr_addr = waddr;
            wr_data = wdata;
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        wr_en = 1'b0;
        if (exp_q.size() != 0) begin
            check("slot_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        mon_on = 1'b0;
        if (wcyc != 0 && int'(waddr) < M_LEN) msg_m[waddr] = wdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        // Load the message 1..6.
        do_reset();
        for (int i = 0; i < M_LEN; i++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(i);
            wr_data = 4'(i + 1);
            msg_m[i] = 4'(i + 1);
            @(negedge clk);
        end
        wr_en = 1'b0;

        // Reset state holds until the first scan tick.
        do_reset();
        for (int c = 1; c <= 3; c++) begin
            cycles(1);
            check("rst_dsel", {28'd0, digit_sel}, 32'hF);
            check("rst_seg", {25'd0, seg}, 32'h0);
            check("rst_pos", {29'd0, pos}, 32'h0);
        end

        // Hold, plus an out-of-range write that must change nothing.
        run_phase(2'b00, 1'b0, 8, 2, 3'd7, 4'h0);
        run_phase(2'b01, 1'b0, 28, 0, 3'd0, 4'h0);
        run_phase(2'b10, 1'b0, 8, 0, 3'd0, 4'h0);
        run_phase(2'b11, 1'b1, 12, 0, 3'd0, 4'h0);
        // Write to addr 2 on the same edge that lights digit 2.
        run_phase(2'b00, 1'b0, 8, 12, 3'd2, 4'hA);

        // Reach pos 5 by wrap-right, then enter bounce: clamp to top, heading down.
        mode = 2'b10;
        fast = 1'b1;
        do_reset();
        cycles(8);
        check("clamp_pre", {29'd0, pos}, 32'd5);
        mode = 2'b11;
        cycles(8);
        check("clamp_top", {29'd0, pos}, 32'd2);
        cycles(8);
        check("clamp_down1", {29'd0, pos}, 32'd1);
        cycles(8);
        check("clamp_down0", {29'd0, pos}, 32'd0);
        cycles(8);
        check("clamp_up1", {29'd0, pos}, 32'd1);

        // Switching to fast with the counter already past the fast terminal steps at once.
        mode = 2'b01;
        fast = 1'b0;
        do_reset();
        cycles(12);
        check("fastsw_before", {29'd0, pos}, 32'd0);
        fast = 1'b1;
        cycles(1);
        check("fastsw_now", {29'd0, pos}, 32'd1);
        cycles(7);
        check("fastsw_hold", {29'd0, pos}, 32'd1);
        cycles(1);
        check("fastsw_next", {29'd0, pos}, 32'd2);

        // Blink blanks seg while the phase is on; digits keep scanning.
        mode     = 2'b00;
        fast     = 1'b0;
        blink_en = 1'b1;
        do_reset();
        for (int e = 1; e <= 23; e++) begin
            int         s;
            logic [6:0] want;
            bit         blank;
            cycles(1);
            s    = e / 4;
            want = (s == 0) ? 7'b0 : hex_ref(msg_m[(s - 1) % N_DIG]);
`ifdef SEG_BLINK_EN
            blank = (e >= 8 && e < 16);
`else
            blank = 1'b0;
`endif
            check("blink_seg", {25'd0, seg}, blank ? 32'h0 : {25'd0, want});
            if (s != 0) check("blink_dsel", {28'd0, digit_sel}, {28'd0, dsel_ref((s - 1) % N_DIG)});
        end
        blink_en = 1'b0;

        // Reset mid-run returns everything except the message.
        mode = 2'b01;
        fast = 1'b1;
        do_reset();
        cycles(20);
        check("midrst_pre", {29'd0, pos}, 32'd2);
        rst = 1'b1;
        cycles(1);
        check("midrst_pos", {29'd0, pos}, 32'd0);
        check("midrst_dsel", {28'd0, digit_sel}, 32'hF);
        check("midrst_seg", {25'd0, seg}, 32'h0);
        rst = 1'b0;
        cycles(4);
        check("midrst_dsel0", {28'd0, digit_sel}, 32'hE);
        check("midrst_seg0", {25'd0, seg}, {25'd0, hex_ref(msg_m[0])});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
